// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - 4-digit common-anode 7-segment scan controller with frame-synchronous double buffering
module display_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        frame_done
);

    localparam int             CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic          run_q, run_d;

    logic [15:0]   pend_val_q, pend_val_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic [3:0]    pend_en_q, pend_en_d;
    logic [15:0]   act_val_q, act_val_d;
    logic [3:0]    act_dp_q, act_dp_d;
    logic [3:0]    act_en_q, act_en_d;

    logic [3:0]    anode_q, anode_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;

    logic [1:0]    slot_idx;
    logic [3:0]    nibble;
    logic          in_blank;
    logic          show;

    // Segment order {g,f,e,d,c,b,a}, active low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        act_en_d     = act_en_q;
        cnt_d        = cnt_q;
        digit_d      = digit_q;
        run_d        = enable;

        if (load) begin
            pend_val_d = value_in;
            pend_dp_d  = dp_in;
            pend_en_d  = digit_en;
        end

        if (!enable) begin
            cnt_d   = '0;
            digit_d = 2'd0;
        end else if (!run_q) begin
            // First enabled edge: restart at digit 0 with a fresh buffer swap.
            cnt_d     = '0;
            digit_d   = 2'd0;
            act_val_d = pend_val_d;
            act_dp_d  = pend_dp_d;
            act_en_d  = pend_en_d;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
            // Using the _d pending values lets a load on the boundary cycle land directly.
            if (digit_q == 2'd3) begin
                act_val_d = pend_val_d;
                act_dp_d  = pend_dp_d;
                act_en_d  = pend_en_d;
            end
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        // Outputs are derived from next state so they change on the same edge as the scan.
        slot_idx = 2'd3 - digit_d;
        nibble   = act_val_d[{slot_idx, 2'b00} +: 4];
        in_blank = (BLANK_CYCLES != 0) && (cnt_d < BLANK_END);
        show     = enable && act_en_d[slot_idx] && !in_blank;

        anode_d = 4'b1111;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        if (show) begin
            anode_d = ~(4'b1000 >> digit_d);
            seg_d   = hex_to_seg(nibble);
            dp_d    = ~act_dp_d[slot_idx];
        end

        frame_done_d = enable && (digit_d == 2'd3) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            run_q        <= 1'b1;
            pend_val_q   <= 16'h0000;
            pend_dp_q    <= 4'b0000;
            pend_en_q    <= 4'b1111;
            act_val_q    <= 16'h0000;
            act_dp_q     <= 4'b0000;
            act_en_q     <= 4'b1111;
            anode_q      <= 4'b1111;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            run_q        <= run_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anode      = anode_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_sel  = digit_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - randomized model-based bench for display_scan_controller
module tb_display_scan_controller;

    localparam int R     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * R;
    localparam logic [14:0] RST_VEC = {4'b1111, 7'h7F, 1'b1, 2'd0, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        frame_done;

    logic        rst2_n = 1'b0;
    logic [3:0]  anode2;
    logic [6:0]  seg2;
    logic        dp2;
    logic [1:0]  digit_sel2;
    logic        frame_done2;

    int total = 0;
    int bad = 0;

    logic [6:0] seg_tab [16];

    int          m_pos;
    bit          m_dis;
    logic [15:0] m_pv, m_av;
    logic [3:0]  m_pd, m_ad, m_pe, m_ae;

    always #5 clk = ~clk;

    display_scan_controller #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .value_in(value_in), .dp_in(dp_in), .digit_en(digit_en),
        .anode(anode), .seg(seg), .dp(dp), .digit_sel(digit_sel), .frame_done(frame_done)
    );

    display_scan_controller #(.REFRESH_DIV(R), .BLANK_CYCLES(0)) dut_nb (
        .clk(clk), .rst_n(rst2_n), .enable(1'b1), .load(1'b0),
        .value_in(16'h0000), .dp_in(4'h0), .digit_en(4'hF),
        .anode(anode2), .seg(seg2), .dp(dp2), .digit_sel(digit_sel2), .frame_done(frame_done2)
    );

    function automatic logic [14:0] observed();
        return {anode, seg, dp, digit_sel, frame_done};
    endfunction

    // What the display should show at scan position pos of a frame.
    function automatic logic [14:0] expected();
        int d, c, k;
        logic [3:0] an;
        logic [6:0] sg;
        logic       p, fd;
        if (m_dis) return RST_VEC;
        d  = m_pos / R;
        c  = m_pos % R;
        k  = 3 - d;
        fd = (d == 3) && (c == R - 1);
        an = 4'b1111;
        sg = 7'h7F;
        p  = 1'b1;
        if (c >= B && m_ae[k]) begin
            an = 4'b1111;
            an[k] = 1'b0;
            sg = seg_tab[m_av[4*k +: 4]];
            p  = ~m_ad[k];
        end
        return {an, sg, p, d[1:0], fd};
    endfunction

    task automatic model_reset();
        m_pos = 0; m_dis = 0;
        m_pv = 16'h0; m_pd = 4'h0; m_pe = 4'hF;
        m_av = 16'h0; m_ad = 4'h0; m_ae = 4'hF;
    endtask

    // One clock edge; the model advances using the inputs that were applied for it.
    task automatic tick();
        logic [15:0] nv;
        logic [3:0]  nd, ne;
        bit          swap;
        @(posedge clk);
        nv = load ? value_in : m_pv;
        nd = load ? dp_in : m_pd;
        ne = load ? digit_en : m_pe;
        swap = 0;
        if (!enable) begin
            m_pos = 0;
            m_dis = 1;
        end else if (m_dis) begin
            m_pos = 0;
            m_dis = 0;
            swap = 1;
        end else begin
            swap  = (m_pos == FRAME - 1);
            m_pos = (m_pos + 1) % FRAME;
        end
        if (swap) begin
            m_av = nv; m_ad = nd; m_ae = ne;
        end
        m_pv = nv; m_pd = nd; m_pe = ne;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        load = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (observed() !== RST_VEC) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", observed(), RST_VEC);
        end
    endtask

    task automatic test_basic_scan();
        int pulses = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (frame_done === 1'b1) pulses++;
            total++;
            if (observed() !== expected()) begin
                bad++;
                $display("FAIL basic_scan cyc=%0d got=%h want=%h", i, observed(), expected());
            end
        end
        total++;
        if (pulses != 2) begin
            bad++;
            $display("FAIL basic_frame_done_count got=%0d want=2", pulses);
        end
    endtask

    task automatic test_load_midframe();
        while (m_pos != 13) tick();
        value_in = 16'h1A8F; dp_in = 4'b0101; digit_en = 4'b1111; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            total++;
            if (observed() !== expected()) begin
                bad++;
                $display("FAIL load_midframe cyc=%0d got=%h want=%h", i, observed(), expected());
            end
            if (m_pos == R + 4) begin
                total++;
                if ({seg, dp} !== {7'h08, 1'b0}) begin
                    bad++;
                    $display("FAIL load_digit1_const got=%h want=%h", {seg, dp}, {7'h08, 1'b0});
                end
            end
        end
    endtask

    task automatic test_digit_disable();
        int frame_len = 0;
        value_in = 16'h1234; dp_in = 4'b0000; digit_en = 4'b1011; load = 1'b1;
        tick();
        load = 1'b0;
        while (m_pos != 0) tick();
        for (int i = 0; i < FRAME; i++) begin
            tick();
            frame_len++;
            total++;
            if (observed() !== expected()) begin
                bad++;
                $display("FAIL digit_disable cyc=%0d got=%h want=%h", i, observed(), expected());
            end
            if (m_pos >= R && m_pos < 2 * R) begin
                total++;
                if (anode !== 4'b1111) begin
                    bad++;
                    $display("FAIL digit1_off got=%b want=1111", anode);
                end
            end
            if (frame_done === 1'b1) break;
        end
        total++;
        if (frame_len != FRAME - 1) begin
            bad++;
            $display("FAIL disable_frame_len got=%0d want=%0d", frame_len, FRAME - 1);
        end
    endtask

    task automatic test_load_on_boundary();
        value_in = 16'hFFFF; dp_in = 4'h0; digit_en = 4'hF; load = 1'b1;
        tick();
        load = 1'b0;
        while (m_pos != FRAME - 1) tick();
        value_in = 16'h2345; dp_in = 4'h0; digit_en = 4'hF; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            total++;
            if (observed() !== expected()) begin
                bad++;
                $display("FAIL boundary_load cyc=%0d got=%h want=%h", i, observed(), expected());
            end
            if (m_pos == 3 * R + 5) begin
                total++;
                if (seg !== 7'h12) begin
                    bad++;
                    $display("FAIL boundary_digit3_const got=%h want=12", seg);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        while (m_pos != 2 * R + 4) tick();
        value_in = 16'h9C0E; dp_in = 4'b1001; digit_en = 4'hF; load = 1'b1;
        enable = 1'b0;
        tick();
        load = 1'b0;
        total++;
        if (observed() !== RST_VEC) begin
            bad++;
            $display("FAIL enable_drop_blank got=%h want=%h", observed(), RST_VEC);
        end
        repeat (5) tick();
        enable = 1'b1;
        for (int i = 0; i < FRAME + 4; i++) begin
            tick();
            total++;
            if (observed() !== expected()) begin
                bad++;
                $display("FAIL enable_restart cyc=%0d got=%h want=%h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_async_reset();
        while (m_pos != R + 5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (observed() !== RST_VEC) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", observed(), RST_VEC);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < FRAME + 3; i++) begin
            tick();
            total++;
            if (observed() !== expected()) begin
                bad++;
                $display("FAIL after_reset cyc=%0d got=%h want=%h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            load     = ($urandom_range(0, 7) == 0);
            value_in = 16'($urandom);
            dp_in    = 4'($urandom);
            digit_en = 4'($urandom);
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            tick();
            total++;
            if (observed() !== expected()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, observed(), expected());
            end
        end
        load = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_no_blank();
        logic [3:0] want;
        rst2_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst2_n = 1'b1;
        total++;
        if (anode2 !== 4'b1111) begin
            bad++;
            $display("FAIL noblank_reset got=%b want=1111", anode2);
        end
        for (int k = 1; k < FRAME + 4; k++) begin
            @(posedge clk);
            #1;
            want = 4'b1111;
            want[3 - ((k % FRAME) / R)] = 1'b0;
            total++;
            if ({anode2, seg2} !== {want, 7'h40}) begin
                bad++;
                $display("FAIL noblank cyc=%0d got=%h want=%h", k, {anode2, seg2}, {want, 7'h40});
            end
        end
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        model_reset();
        test_reset();
        test_basic_scan();
        test_load_midframe();
        test_digit_disable();
        test_load_on_boundary();
        test_enable_drop();
        test_async_reset();
        test_random();
        test_no_blank();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
